// File: rtl/paddle_ctrl_pkg.sv
// Shared definitions for the player-input stage: state encodings, screen
// limits for the paddle, bus widths and the clamped paddle-step helper.
package paddle_ctrl_pkg;

    localparam int X_W    = 12;
    localparam int SEED_W = 21;

    typedef logic [X_W-1:0]    xpos_t;
    typedef logic [SEED_W-1:0] seed_t;
    typedef logic [1:0]        state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PLAY  = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_OVER  = 2'd3;

    localparam xpos_t X_MIN  = 12'd0;
    localparam xpos_t X_MAX  = 12'd540;
    localparam xpos_t X_INIT = 12'd300;

    // One paddle step, done one bit wider than X so the left move cannot wrap.
    // Both or neither direction leaves the position alone.
    function automatic xpos_t step_x(input xpos_t x, input logic left,
                                     input logic right, input logic [X_W:0] px);
        logic [X_W:0] wide;
        logic [X_W:0] lo;
        logic [X_W:0] hi;
        wide   = {1'b0, x};
        lo     = {1'b0, X_MIN} + px;
        hi     = wide + px;
        step_x = x;
        if (left && !right) begin
            if (wide < lo) begin
                step_x = X_MIN;
            end else begin
                step_x = x - px[X_W-1:0];
            end
        end else if (right && !left) begin
            if (hi > {1'b0, X_MAX}) begin
                step_x = X_MAX;
            end else begin
                step_x = hi[X_W-1:0];
            end
        end
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Bus between the player-input stage and its surroundings: raw buttons and
// the engine's round-over flag in, paddle/game-control signals out.
interface paddle_ctrl_if;
    import paddle_ctrl_pkg::*;

    logic   btn_left;
    logic   btn_right;
    logic   btn_start;
    logic   btn_pause;
    logic   end_show;
    xpos_t  p_x;
    logic   ena;
    seed_t  seed;
    logic   restart;
    state_t state_o;

    modport slave (
        input  btn_left, btn_right, btn_start, btn_pause, end_show,
        output p_x, ena, seed, restart, state_o
    );

    modport master (
        output btn_left, btn_right, btn_start, btn_pause, end_show,
        input  p_x, ena, seed, restart, state_o
    );

endinterface

// File: rtl/paddle_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, then a stability counter.
// The level only flips after DEB_CYCLES consecutive synchronised samples that
// disagree with it; rise is a one-clock pulse on a 0->1 flip.
module paddle_ctrl_btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    // Synchronise the raw pin, count disagreeing samples, flip when stable long enough.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_a <= din;
            sync_b <= sync_a;
            rise   <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync_b;
                rise  <= sync_b;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Player-input stage: debounces the four buttons, runs the IDLE/PLAY/PAUSE/OVER
// game-mode FSM, moves the paddle while a direction is held in PLAY, latches the
// random seed on the start press and pulses restart when a finished round is left.
module paddle_ctrl
    import paddle_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int STEP_CYCLES = 250_000,
    parameter int STEP_PX     = 4
) (
    input  logic            clk,
    input  logic            rst,
    paddle_ctrl_if.slave    bus
);

    localparam int T_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [T_W-1:0] T_LAST = T_W'(STEP_CYCLES - 1);
    localparam logic [X_W:0]   PX     = (X_W + 1)'(STEP_PX);

    logic   left_lvl, right_lvl, start_lvl, pause_lvl;
    logic   left_rise, right_rise, start_rise, pause_rise;
    logic   es_a, es_b, es_d;
    logic   eos;
    logic   held;
    state_t state;
    state_t next_state;
    seed_t  seed_cnt;
    seed_t  seed;
    xpos_t  p_x;
    logic   ena;
    logic   restart;
    logic   [T_W-1:0] timer;
    logic   unused_ok;

    paddle_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_left (
        .clk(clk), .rst(rst), .din(bus.btn_left), .level(left_lvl), .rise(left_rise)
    );
    paddle_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_right (
        .clk(clk), .rst(rst), .din(bus.btn_right), .level(right_lvl), .rise(right_rise)
    );
    paddle_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
        .clk(clk), .rst(rst), .din(bus.btn_start), .level(start_lvl), .rise(start_rise)
    );
    paddle_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pause (
        .clk(clk), .rst(rst), .din(bus.btn_pause), .level(pause_lvl), .rise(pause_rise)
    );

    assign unused_ok = &{1'b0, left_rise, right_rise, start_lvl, pause_lvl};
    assign held      = left_lvl | right_lvl;

    // end_show comes from a divided clock: synchronise it and keep one delayed copy for the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            es_a <= 1'b0;
            es_b <= 1'b0;
            es_d <= 1'b0;
        end else begin
            es_a <= bus.end_show;
            es_b <= es_a;
            es_d <= es_b;
        end
    end

    assign eos = es_b & ~es_d;

    // Free-running seed source, wraps naturally at 21 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_cnt <= '0;
        end else begin
            seed_cnt <= seed_cnt + 21'd1;
        end
    end

    // Game-mode transitions; pause beats a same-cycle end-of-round in PLAY.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start_rise) next_state = ST_PLAY;
            ST_PLAY:  begin
                if (pause_rise) begin
                    next_state = ST_PAUSE;
                end else if (eos) begin
                    next_state = ST_OVER;
                end
            end
            ST_PAUSE: if (pause_rise) next_state = ST_PLAY;
            default:  if (start_rise) next_state = ST_IDLE;
        endcase
    end

    // State register plus the outputs that follow it: ena, restart pulse and seed capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            ena     <= 1'b0;
            restart <= 1'b0;
            seed    <= 21'd1;
        end else begin
            state   <= next_state;
            ena     <= (next_state == ST_PLAY);
            restart <= (state == ST_OVER) && (next_state == ST_IDLE);
            if ((state == ST_IDLE) && (next_state == ST_PLAY)) begin
                seed <= (seed_cnt == '0) ? 21'd1 : seed_cnt;
            end
        end
    end

    // Paddle movement: step on the timer's terminal count while held in a steady PLAY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
            p_x   <= X_INIT;
        end else if ((state == ST_OVER) && (next_state == ST_IDLE)) begin
            timer <= '0;
            p_x   <= X_INIT;
        end else if ((state == ST_PLAY) && (next_state == ST_PLAY) && held) begin
            if (timer == T_LAST) begin
                timer <= '0;
                p_x   <= step_x(p_x, left_lvl, right_lvl, PX);
            end else begin
                timer <= timer + T_W'(1);
            end
        end else begin
            timer <= '0;
        end
    end

    assign bus.p_x     = p_x;
    assign bus.ena     = ena;
    assign bus.seed    = seed;
    assign bus.restart = restart;
    assign bus.state_o = state;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl with short debounce/step periods. A behavioural model
// driven by the raw input history predicts every output each cycle; directed
// phases add literal expectations, then a randomised phase exercises the rest.
module tb_paddle_ctrl;

    localparam int DEB  = 4;
    localparam int STEP = 8;
    localparam int PX   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    paddle_ctrl_if bus();

    paddle_ctrl #(
        .DEB_CYCLES(DEB),
        .STEP_CYCLES(STEP),
        .STEP_PX(PX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errCount   = 0;
    int checkCount = 0;
    int restartSeen = 0;

    logic hist [5][16];
    logic mLevel [4];
    logic mRise [4];
    int   mState, mPx, mRun, mCnt, mSeed;
    logic mEna, mRestart;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 16; i++) hist[k][i] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            mLevel[k] = 1'b0;
            mRise[k]  = 1'b0;
        end
        mState = 0; mPx = 300; mRun = 0; mCnt = 0; mSeed = 1;
        mEna = 1'b0; mRestart = 1'b0;
    endtask

    // Behavioural model: buttons are seen two edges late, flip after DEB
    // consecutive disagreeing samples; end-of-round is the edge of end_show seen two edges late.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                modelReset();
            end else begin
                logic raw [5];
                logic eos, l, r, allDiff;
                int   nxt;
                raw[0] = bus.btn_left;  raw[1] = bus.btn_right;
                raw[2] = bus.btn_start; raw[3] = bus.btn_pause;
                raw[4] = bus.end_show;
                for (int k = 0; k < 5; k++) begin
                    for (int i = 15; i > 0; i--) hist[k][i] = hist[k][i-1];
                    hist[k][0] = raw[k];
                end
                eos = hist[4][2] && !hist[4][3];
                l = mLevel[0];
                r = mLevel[1];
                nxt = mState;
                case (mState)
                    0: if (mRise[2]) nxt = 1;
                    1: if (mRise[3]) nxt = 2; else if (eos) nxt = 3;
                    2: if (mRise[3]) nxt = 1;
                    default: if (mRise[2]) nxt = 0;
                endcase
                if (mState == 0 && nxt == 1) mSeed = (mCnt == 0) ? 1 : mCnt;
                mRestart = (mState == 3 && nxt == 0);
                if (mRestart) mPx = 300;
                if (mState == 1 && nxt == 1 && (l || r)) begin
                    mRun++;
                    if (mRun == STEP) begin
                        mRun = 0;
                        if (l && !r) mPx = (mPx - PX < 0) ? 0 : mPx - PX;
                        else if (r && !l) mPx = (mPx + PX > 540) ? 540 : mPx + PX;
                    end
                end else begin
                    mRun = 0;
                end
                mState = nxt;
                mEna   = (nxt == 1);
                mCnt   = (mCnt + 1) % (1 << 21);
                for (int k = 0; k < 4; k++) begin
                    mRise[k] = 1'b0;
                    allDiff  = 1'b1;
                    for (int i = 2; i <= DEB + 1; i++) begin
                        if (hist[k][i] == mLevel[k]) allDiff = 1'b0;
                    end
                    if (allDiff) begin
                        mLevel[k] = !mLevel[k];
                        mRise[k]  = mLevel[k];
                    end
                end
            end
        end
    end

    // Every cycle out of reset, the DUT outputs must match the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                checkOutput("cyc_p_x", 32'(bus.p_x), mPx);
                checkOutput("cyc_ena", 32'(bus.ena), 32'(mEna));
                checkOutput("cyc_state", 32'(bus.state_o), mState);
                checkOutput("cyc_restart", 32'(bus.restart), 32'(mRestart));
                checkOutput("cyc_seed", 32'(bus.seed), mSeed);
                if (bus.restart) restartSeen++;
            end
        end
    end

    task automatic applyStimulus(input logic l, input logic r, input logic s,
                                 input logic p, input logic e, input int cycles);
        bus.btn_left  = l;
        bus.btn_right = r;
        bus.btn_start = s;
        bus.btn_pause = p;
        bus.end_show  = e;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int savedPx;
        logic found;
        bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_start = 1'b0;
        bus.btn_pause = 1'b0; bus.end_show = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_p_x", 32'(bus.p_x), 300);
        checkOutput("reset_seed", 32'(bus.seed), 1);
        rst = 1'b1;

        $display("[TB] idle after reset");
        applyStimulus(0, 0, 0, 0, 0, 50);
        checkOutput("idle_p_x", 32'(bus.p_x), 300);
        checkOutput("idle_ena", 32'(bus.ena), 0);
        checkOutput("idle_state", 32'(bus.state_o), 0);
        checkOutput("idle_no_restart", restartSeen, 0);

        $display("[TB] start glitch and press");
        applyStimulus(0, 0, 1, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 20);
        checkOutput("glitch_state", 32'(bus.state_o), 0);
        applyStimulus(0, 0, 1, 0, 0, 10);
        applyStimulus(0, 0, 0, 0, 0, 5);
        checkOutput("start_state", 32'(bus.state_o), 1);
        checkOutput("start_ena", 32'(bus.ena), 1);
        checkOutput("seed_nonzero", 32'(bus.seed != '0), 1);

        $display("[TB] movement and saturation");
        applyStimulus(0, 1, 0, 0, 0, 8 * 70);
        checkOutput("right_sat", 32'(bus.p_x), 540);
        applyStimulus(1, 1, 0, 0, 0, 100);
        checkOutput("both_at_max", 32'(bus.p_x), 540);
        applyStimulus(1, 0, 0, 0, 0, 8 * 140);
        checkOutput("left_sat", 32'(bus.p_x), 0);
        applyStimulus(1, 1, 0, 0, 0, 100);
        checkOutput("both_at_min", 32'(bus.p_x), 0);
        applyStimulus(0, 1, 0, 0, 0, 200);
        applyStimulus(0, 0, 0, 0, 0, 10);
        checkOutput("right_moved", 32'(bus.p_x > 12'd0), 1);

        $display("[TB] pause behaviour");
        applyStimulus(0, 0, 0, 1, 0, 10);
        applyStimulus(0, 0, 0, 0, 0, 5);
        checkOutput("pause_state", 32'(bus.state_o), 2);
        checkOutput("pause_ena", 32'(bus.ena), 0);
        savedPx = mPx;
        applyStimulus(1, 0, 0, 0, 0, 100);
        checkOutput("pause_hold_p_x", 32'(bus.p_x), savedPx);
        applyStimulus(0, 0, 0, 0, 0, 10);
        applyStimulus(0, 0, 0, 1, 0, 10);
        applyStimulus(0, 0, 0, 0, 0, 5);
        checkOutput("unpause_ena", 32'(bus.ena), 1);
        applyStimulus(0, 0, 0, 1, 0, DEB);
        applyStimulus(0, 0, 0, 1, 1, 6);
        applyStimulus(0, 0, 0, 0, 1, 10);
        checkOutput("pause_beats_eos", 32'(bus.state_o), 2);
        applyStimulus(0, 0, 0, 0, 0, 10);
        applyStimulus(0, 0, 0, 1, 0, 10);
        applyStimulus(0, 0, 0, 0, 0, 10);
        checkOutput("replay_state", 32'(bus.state_o), 1);

        $display("[TB] end of round and restart");
        bus.end_show = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.state_o == 2'd3) found = 1'b1;
        end
        checkOutput("over_within_3", 32'(found), 1);
        checkOutput("over_ena", 32'(bus.ena), 0);
        restartSeen = 0;
        applyStimulus(0, 0, 1, 0, 1, 10);
        applyStimulus(0, 0, 0, 0, 0, 5);
        checkOutput("restart_once", restartSeen, 1);
        checkOutput("restart_state", 32'(bus.state_o), 0);
        checkOutput("restart_p_x", 32'(bus.p_x), 300);

        $display("[TB] reset mid-play");
        applyStimulus(0, 0, 1, 0, 0, 10);
        applyStimulus(0, 1, 0, 0, 0, 30);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_p_x", 32'(bus.p_x), 300);
        checkOutput("rst_ena", 32'(bus.ena), 0);
        checkOutput("rst_state", 32'(bus.state_o), 0);
        checkOutput("rst_restart", 32'(bus.restart), 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 2);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 30);
        checkOutput("post_rst_state", 32'(bus.state_o), 0);

        $display("[TB] randomised play");
        for (int n = 0; n < 150; n++) begin
            logic rl, rr, rs, rp, re;
            rl = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 5) == 0);
            rp = ($urandom_range(0, 7) == 0);
            re = ($urandom_range(0, 4) == 0) ? !bus.end_show : bus.end_show;
            applyStimulus(rl, rr, rs, rp, re, $urandom_range(1, 30));
        end
        applyStimulus(0, 0, 0, 0, 0, 20);

        $display("[TB] Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
